// File: rtl/snn_neuron_scheduler.sv
// snn_neuron_scheduler: one time-multiplexed leaky integrate-and-fire datapath shared by N virtual neurons
// Ports: clk/rst_n (async active-low); ena freezes the block; step starts a timestep and latches in_spikes;
// cfg_we/cfg_addr/cfg_data write weight[i] (addr<N), threshold (addr N) or clear all membranes (addr N+1);
// dbg_addr/dbg_v read a membrane combinationally; spikes holds the last timestep result; busy/done report progress.
module snn_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH = 8,
  parameter int LEAK_SHIFT = 2,
  parameter int THRESH_INIT = 100,
  localparam int AW = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 step,
  input  logic [N_NEURONS-1:0] in_spikes,
  input  logic                 cfg_we,
  input  logic [AW:0]          cfg_addr,
  input  logic [V_WIDTH-1:0]   cfg_data,
  input  logic [AW-1:0]        dbg_addr,
  output logic [V_WIDTH-1:0]   dbg_v,
  output logic [N_NEURONS-1:0] spikes,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;
  state_t state_q, state_d;
  logic [V_WIDTH-1:0] v [N_NEURONS];
  logic [V_WIDTH-1:0] weight [N_NEURONS];
  logic [V_WIDTH-1:0] thr, op_v, op_w, v1, v2;
  logic [V_WIDTH:0] sum;
  logic [AW-1:0] idx;
  logic [N_NEURONS-1:0] in_lat, spk_acc, spk_next;
  logic fire, last;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign dbg_v = v[dbg_addr];
  // The extra carry bit of sum detects overflow so the result saturates instead of wrapping.
  always_comb begin
    v1 = op_v - (op_v >> LEAK_SHIFT);
    sum = {1'b0, v1} + (in_lat[idx] ? {1'b0, op_w} : '0);
    v2 = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];
    fire = v2 >= thr;
    last = &idx;
    spk_next = spk_acc;
    spk_next[idx] = fire;
  end
  always_comb begin
    state_d = !ena                ? state_q :
              state_q == IDLE     ? (step ? FETCH : IDLE) :
              state_q == FETCH    ? UPDATE :
              state_q == UPDATE   ? (last ? DONE : FETCH) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Config writes only land while idle so a running timestep always sees a stable parameter set.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i] <= '0;
        weight[i] <= '0;
      end
      thr <= V_WIDTH'(THRESH_INIT);
      op_v <= '0;
      op_w <= '0;
      idx <= '0;
      in_lat <= '0;
      spk_acc <= '0;
      spikes <= '0;
    end else if (ena) begin
      if (state_q == IDLE) begin
        if (step) begin
          in_lat <= in_spikes;
          idx <= '0;
        end
        if (cfg_we && !cfg_addr[AW]) weight[cfg_addr[AW-1:0]] <= cfg_data;
        if (cfg_we && cfg_addr == {1'b1, AW'(0)}) thr <= cfg_data;
        if (cfg_we && cfg_addr == {1'b1, AW'(1)})
          for (int i = 0; i < N_NEURONS; i++) v[i] <= '0;
      end
      if (state_q == FETCH) begin
        op_v <= v[idx];
        op_w <= weight[idx];
      end
      if (state_q == UPDATE) begin
        v[idx] <= fire ? '0 : v2;
        spk_acc <= spk_next;
        idx <= idx + 1'b1;
        if (last) spikes <= spk_next;
      end
    end
endmodule

// File: tb/tb_snn_neuron_scheduler.sv
// tb_snn_neuron_scheduler: directed and randomized timesteps checked against an arithmetic LIF reference model
module tb_snn_neuron_scheduler;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, ena = 1, step = 0, cfg_we = 0;
  logic [N-1:0] in_spikes = '0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [1:0] dbg_addr = '0;
  logic [7:0] dbg_v;
  logic [N-1:0] spikes;
  logic busy, done;
  int mv[N], mw[N], mthr;
  int pass_n = 0, total_n = 0;
  snn_neuron_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .step(step), .in_spikes(in_spikes),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .dbg_addr(dbg_addr),
    .dbg_v(dbg_v), .spikes(spikes), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic check_all_v(input string tag);
    for (int i = 0; i < N; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("%s_v%0d", tag, i), 32'(dbg_v), 32'(mv[i]));
    end
  endtask
  task automatic model_step(input logic [N-1:0] sp, output logic [N-1:0] es);
    for (int i = 0; i < N; i++) begin
      int a;
      a = mv[i] - mv[i] / 4 + (sp[i] ? mw[i] : 0);
      if (a > 255) a = 255;
      es[i] = a >= mthr;
      mv[i] = es[i] ? 0 : a;
    end
  endtask
  task automatic cfg_write(input int a, input int d);
    @(negedge clk);
    cfg_we = 1;
    cfg_addr = 3'(a);
    cfg_data = 8'(d);
    @(posedge clk);
    #1 cfg_we = 0;
    if (a < N) mw[a] = d;
    else if (a == N) mthr = d;
    else if (a == N + 1) for (int i = 0; i < N; i++) mv[i] = 0;
  endtask
  task automatic run_step(input logic [N-1:0] sp, input int gate, input bit prot, input string tag);
    logic [N-1:0] es;
    int lat, bc, dc, exp_lat;
    lat = 0; bc = 0; dc = 0;
    exp_lat = 9 + (gate != 0 ? 3 : 0);
    @(negedge clk);
    in_spikes = sp;
    step = 1;
    @(posedge clk);
    #1 step = 0;
    in_spikes = 4'($urandom);
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      bc += int'(busy);
      if (done) begin dc++; lat = c; end
      if (prot && c == 3) begin step = 1; cfg_we = 1; cfg_addr = 3'd1; cfg_data = 8'd99; end
      if (prot && c == 4) begin step = 0; cfg_addr = 3'd5; end
      if (prot && c == 6) cfg_we = 0;
      if (gate != 0 && c == gate) ena = 0;
      if (gate != 0 && c == gate + 3) ena = 1;
    end
    @(negedge clk);
    chk($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
    dc += int'(done);
    repeat (2) begin @(negedge clk); dc += int'(done); end
    model_step(sp, es);
    chk($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_busy_cycles", tag), 32'(bc), 32'(exp_lat));
    chk($sformatf("%s_done_pulses", tag), 32'(dc), 32'd1);
    chk($sformatf("%s_spikes", tag), 32'(spikes), 32'(es));
    check_all_v(tag);
  endtask
  initial begin
    int dn;
    mthr = 100;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mw[i] = 0; end
    #3;
    chk("reset_spikes", 32'(spikes), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    check_all_v("reset");
    @(negedge clk) rst_n = 1;
    cfg_write(0, 33);
    cfg_write(N, 0);
    run_step(4'b1010, 0, 0, "thr0");
    cfg_write(1, 50);
    @(negedge clk);
    in_spikes = 4'b0011;
    step = 1;
    @(posedge clk);
    #1 step = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    mthr = 100;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mw[i] = 0; end
    chk("abort_spikes", 32'(spikes), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    check_all_v("abort");
    @(negedge clk) rst_n = 1;
    dn = 0;
    repeat (12) begin @(negedge clk); dn += int'(done); end
    chk("abort_no_done", 32'(dn), 32'd0);
    cfg_write(0, 60);
    run_step(4'b0001, 0, 0, "integrate");
    run_step(4'b0001, 0, 0, "fire");
    run_step(4'b0001, 0, 0, "leak_load");
    run_step(4'b0000, 0, 0, "leak1");
    run_step(4'b0000, 0, 0, "leak2");
    cfg_write(N, 255);
    cfg_write(2, 200);
    run_step(4'b0100, 0, 0, "sat1");
    run_step(4'b0100, 0, 0, "sat2");
    cfg_write(1, 7);
    run_step(4'b0010, 0, 1, "protect");
    run_step(4'b0010, 0, 0, "protect_w1");
    cfg_write(N + 1, 0);
    check_all_v("clear");
    cfg_write(N, 100);
    cfg_write(0, 60);
    run_step(4'b0001, 0, 0, "ungated");
    run_step(4'b0001, 3, 0, "gated");
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 2)) cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      run_step(4'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0,
               1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
